imul_mac_seq: RTL and testbench
===============================

IMUL_MAC_SEQ -- requirements
Module: imul_mac_seq

Interface
REQ-001 The module SHALL have parameter p_depth, default 2, giving the number of entries in the last-flag queue (outstanding multiply requests); legal values are 2 and 4.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_req_val  input  1  operand pair valid.
REQ-005 in_req_rdy  output  1  operand pair accepted when high together with in_req_val.
REQ-006 in_req_msg  input  65  bit 64 = last flag; bits 63:32 = a; bits 31:0 = b.
REQ-007 mul_req_val  output  1  request valid toward the downstream multiplier.
REQ-008 mul_req_rdy  input  1  multiplier ready.
REQ-009 mul_req_msg  output  64  {a,b}, in the multiplier's request format.
REQ-010 mul_resp_val  input  1  product valid from the multiplier.
REQ-011 mul_resp_rdy  output  1  product consumed when high together with mul_resp_val.
REQ-012 mul_resp_msg  input  32  product (low 32 bits).
REQ-013 out_val  output  1  accumulated result valid.
REQ-014 out_rdy  input  1  result consumer ready.
REQ-015 out_msg  output  32  sum of the products of one group.
REQ-016 out_count  output  8  number of products in that group.

Function
REQ-017 The module SHALL hold a FIFO of p_depth 1-bit last flags, one entry per in-flight multiply.
REQ-018 The flag FIFO SHALL be "full" when it holds p_depth entries and "empty" when it holds 0.
REQ-019 The input-to-multiplier path SHALL be combinational:
- mul_req_msg = in_req_msg[63:0];
- mul_req_val = in_req_val && !full;
- in_req_rdy = mul_req_rdy && !full.
REQ-020 On a req fire (in_req_val && in_req_rdy), in_req_msg[64] SHALL be pushed into the flag FIFO.
REQ-021 Full SHALL be evaluated on registered state only; a pop in the same cycle SHALL NOT enable a push.
REQ-022 The FSM SHALL have two states, ACC and DONE.
REQ-023 mul_resp_rdy SHALL be (state==ACC) && !empty.
REQ-024 On a resp fire in ACC, the module SHALL pop the flag FIFO and compute:
- acc_next = acc + mul_resp_msg, modulo 2^32;
- cnt_next = cnt + 1, saturating at 255.
REQ-025 If the popped flag is 0, acc and cnt SHALL take acc_next and cnt_next, and the state SHALL remain ACC.
REQ-026 If the popped flag is 1:
- out_msg and out_count SHALL register acc_next and cnt_next;
- acc and cnt SHALL clear to 0;
- the state SHALL go to DONE.
REQ-027 In DONE, out_val SHALL be 1 and out_msg/out_count SHALL be held stable.
REQ-028 On an out fire (out_val && out_rdy), the state SHALL return to ACC, and out_val SHALL be 0 from the next cycle.
REQ-029 Input acceptance and multiplier issue SHALL continue during DONE, subject only to full.
REQ-030 Latency from the last product's resp fire to out_val SHALL be exactly 1 cycle.
REQ-031 A push and a pop in the same cycle SHALL both take effect; the occupancy is unchanged.
REQ-032 Pointers SHALL wrap modulo p_depth.
REQ-033 A group of one pair with last=1 SHALL produce out_count=1.
REQ-034 mul_resp_val while empty is a protocol violation; the module SHALL NOT consume the product (mul_resp_rdy=0).

Reset
REQ-035 While reset is low, the module SHALL asynchronously set:
- state to ACC;
- acc and cnt to 0;
- the flag FIFO to empty (pointers 0);
- out_val, out_msg and out_count to 0.
REQ-036 Combinational outputs SHALL then follow from that state: in_req_rdy=mul_req_rdy, mul_req_val=in_req_val, mul_resp_rdy=0.
REQ-037 A reset asserted mid-group SHALL discard partial sums and in-flight flags; products arriving after reset SHALL NOT be consumed until new requests are issued.

Verification
REQ-038 Single pair: (a=3, b=5, last=1), multiplier returns 15 -> out_msg=15 and out_count=1 one cycle after the resp fire.
REQ-039 Three-pair group:
- stimulus: (2,3,0), (4,5,0), (6,7,1);
- required response: out_msg=68, out_count=3, exactly one out_val pulse.
REQ-040 Backpressure:
- p_depth=2, mul_resp_val held 0, three pairs offered;
- required: in_req_rdy=0 after two accepts;
- after one resp fire, the third pair is accepted in the following cycle, not the same cycle.
REQ-041 DONE stall:
- out_rdy=0 for 5 cycles while the next group's products arrive;
- required: mul_resp_rdy=0 and out_msg stable throughout;
- after out_rdy=1, the second group's sum is correct.
REQ-042 Wrap and saturation:
- 300 pairs (1,1), last only on the final pair, out_rdy=1;
- required: out_msg=300, out_count=255;
- separately, products 0xFFFFFFFF + 2 give out_msg=1.
REQ-043 Reset mid-group:
- stimulus: (5,5,0) accepted and product returned, then reset pulsed low, then (1,9,1);
- required: out_msg=9, out_count=1.

Source files
------------

// File: rtl/imul_mac_seq_if.sv
// Handshake bundle for imul_mac_seq: operand input, multiplier request/response
// and accumulated-result output channels.
interface imul_mac_seq_if;
    logic        in_req_val;
    logic        in_req_rdy;
    logic [64:0] in_req_msg;

    logic        mul_req_val;
    logic        mul_req_rdy;
    logic [63:0] mul_req_msg;

    logic        mul_resp_val;
    logic        mul_resp_rdy;
    logic [31:0] mul_resp_msg;

    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_msg;
    logic [7:0]  out_count;

    // Accumulator side.
    modport slave (
        input  in_req_val, in_req_msg, mul_req_rdy, mul_resp_val, mul_resp_msg, out_rdy,
        output in_req_rdy, mul_req_val, mul_req_msg, mul_resp_rdy, out_val, out_msg, out_count
    );

    // Environment side: operand source, multiplier and result consumer.
    modport master (
        output in_req_val, in_req_msg, mul_req_rdy, mul_resp_val, mul_resp_msg, out_rdy,
        input  in_req_rdy, mul_req_val, mul_req_msg, mul_resp_rdy, out_val, out_msg, out_count
    );
endinterface

// File: rtl/imul_mac_seq.sv
// Sequential multiply-accumulate front end: forwards operand pairs to an external
// multiplier and sums the returned products per group delimited by a last flag.
module imul_mac_seq #(
    parameter int p_depth = 2
) (
    input logic          clk,
    input logic          reset,
    imul_mac_seq_if.slave bus
);
    localparam int ptr_w = $clog2(p_depth);

    typedef logic [ptr_w-1:0] ptr_t;
    typedef logic [ptr_w:0]   occ_t;
    typedef enum logic {ST_ACC, ST_DONE} state_t;

    state_t      state, state_next;
    logic        flags [p_depth];
    ptr_t        wr_ptr, rd_ptr;
    occ_t        occ;
    logic        full, empty, push, pop, pop_flag, close_group;
    logic [31:0] acc, acc_next, out_sum;
    logic [7:0]  cnt, cnt_next, out_cnt;

    function automatic ptr_t bump(input ptr_t p);
        return (p == ptr_t'(p_depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Full looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign full  = (occ == occ_t'(p_depth));
    assign empty = (occ == '0);

    assign bus.mul_req_msg = bus.in_req_msg[63:0];
    assign bus.mul_req_val = bus.in_req_val && !full;
    assign bus.in_req_rdy  = bus.mul_req_rdy && !full;
    assign push            = bus.in_req_val && bus.in_req_rdy;

    assign pop_flag = flags[rd_ptr];
    assign acc_next = acc + bus.mul_resp_msg;
    assign cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_ACC;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first; a missed branch would otherwise infer a latch.
        state_next       = state;
        pop              = 1'b0;
        close_group      = 1'b0;
        bus.mul_resp_rdy = 1'b0;
        bus.out_val      = 1'b0;
        unique case (state)
            ST_ACC: begin
                bus.mul_resp_rdy = !empty;
                pop              = bus.mul_resp_val && !empty;
                if (pop && pop_flag) begin
                    close_group = 1'b1;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.out_val = 1'b1;
                if (bus.out_rdy) state_next = ST_ACC;
            end
            default: state_next = ST_ACC;
        endcase
    end

    // NOTE: flag storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) flags[wr_ptr] <= bus.in_req_msg[64];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + occ_t'(1);
                2'b01:   occ <= occ - occ_t'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            cnt     <= '0;
            out_sum <= '0;
            out_cnt <= '0;
        end else if (pop) begin
            if (close_group) begin
                out_sum <= acc_next;
                out_cnt <= cnt_next;
                acc     <= '0;
                cnt     <= '0;
            end else begin
                acc <= acc_next;
                cnt <= cnt_next;
            end
        end
    end

    assign bus.out_msg   = out_sum;
    assign bus.out_count = out_cnt;
endmodule

// File: tb/tb_imul_mac_seq.sv
// Self-checking bench for imul_mac_seq: behavioural multiplier, operand source queue
// and a result scoreboard filled when each group is queued for driving.
module tb_imul_mac_seq;
    localparam int p_depth = 2;

    typedef struct packed {
        logic        last;
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    typedef struct packed {
        logic [31:0] sum;
        logic [7:0]  cnt;
    } res_t;

    typedef struct packed {
        logic [2:0]       n;
        logic [0:3][31:0] a;
        logic [0:3][31:0] b;
        res_t             exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imul_mac_seq_if bus ();
    imul_mac_seq #(.p_depth(p_depth)) dut (.clk(clk), .reset(reset), .bus(bus));

    pair_t       src [$];
    logic [31:0] mq [$];
    res_t        exp_q [$];
    vec_t        vecs [6];

    int checks = 0;
    int errors = 0;
    int out_fires = 0;
    bit last_pf = 1'b0;
    bit src_en = 1'b1, resp_en = 1'b1, mul_rdy_en = 1'b1, out_rdy_en = 1'b1, jitter = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        bus.in_req_val = src_en && (src.size() > 0);
        bus.in_req_msg = '0;
        if (src.size() > 0) bus.in_req_msg = src[0];
        bus.mul_req_rdy  = jitter ? 1'($urandom_range(0, 1)) : mul_rdy_en;
        bus.mul_resp_val = (jitter ? ($urandom_range(0, 1) == 1) : resp_en) && (mq.size() > 0);
        bus.mul_resp_msg = '0;
        if (mq.size() > 0) bus.mul_resp_msg = mq[0];
        bus.out_rdy = jitter ? 1'($urandom_range(0, 1)) : out_rdy_en;
    endtask

    // One clock: observe handshakes at the falling edge, update models after the rising edge.
    task automatic tick();
        bit   rf, pf, of;
        res_t e;
        @(negedge clk);
        rf = bus.in_req_val && bus.in_req_rdy;
        pf = bus.mul_resp_val && bus.mul_resp_rdy;
        of = bus.out_val && bus.out_rdy;
        if (rf) check("mul_req_msg", 64'(bus.mul_req_msg), {src[0].a, src[0].b});
        if (of) begin
            out_fires++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got out_msg=%0h out_count=%0d with nothing expected",
                         bus.out_msg, bus.out_count);
            end else begin
                e = exp_q.pop_front();
                check("out_msg", 64'(bus.out_msg), 64'(e.sum));
                check("out_count", 64'(bus.out_count), 64'(e.cnt));
            end
        end
        @(posedge clk);
        #1;
        if (pf) void'(mq.pop_front());
        if (rf) begin
            mq.push_back(src[0].a * src[0].b);
            void'(src.pop_front());
        end
        last_pf = pf;
        drive();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i = 0;
        while ((src.size() > 0 || mq.size() > 0 || exp_q.size() > 0) && i < budget) begin
            tick();
            i++;
        end
        checks++;
        if (src.size() > 0 || mq.size() > 0 || exp_q.size() > 0) begin
            errors++;
            $display("FAIL %s_timeout: pending src=%0d products=%0d results=%0d required 0",
                     name, src.size(), mq.size(), exp_q.size());
        end
    endtask

    task automatic load_vec(input vec_t v, input bit with_exp);
        for (int i = 0; i < int'(v.n); i++)
            src.push_back('{last: (i == int'(v.n) - 1), a: v.a[i], b: v.b[i]});
        if (with_exp) exp_q.push_back(v.exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   f0;
        vec_t v;

        vecs[0] = '{n: 3'd1, a: {32'd3, 32'd0, 32'd0, 32'd0}, b: {32'd5, 32'd0, 32'd0, 32'd0},
                    exp: '{sum: 32'd15, cnt: 8'd1}};
        vecs[1] = '{n: 3'd3, a: {32'd2, 32'd4, 32'd6, 32'd0}, b: {32'd3, 32'd5, 32'd7, 32'd0},
                    exp: '{sum: 32'd68, cnt: 8'd3}};
        vecs[2] = '{n: 3'd2, a: {32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0}, b: {32'd1, 32'd2, 32'd0, 32'd0},
                    exp: '{sum: 32'd1, cnt: 8'd2}};
        vecs[3] = '{n: 3'd4, a: {32'd10, 32'd0, 32'h1_0000, 32'd7}, b: {32'd10, 32'd99, 32'h1_0000, 32'd1},
                    exp: '{sum: 32'd107, cnt: 8'd4}};
        vecs[4] = '{n: 3'd1, a: {32'h1234_5678, 32'd0, 32'd0, 32'd0}, b: {32'h10, 32'd0, 32'd0, 32'd0},
                    exp: '{sum: 32'h2345_6780, cnt: 8'd1}};
        vecs[5] = '{n: 3'd2, a: {32'hFFFF, 32'd2, 32'd0, 32'd0}, b: {32'hFFFF, 32'd3, 32'd0, 32'd0},
                    exp: '{sum: 32'hFFFE_0007, cnt: 8'd2}};

        // Reset values and the combinational paths while reset is held.
        reset = 1'b1;
        bus.in_req_val   = 1'b1;
        bus.in_req_msg   = '0;
        bus.mul_req_rdy  = 1'b1;
        bus.mul_resp_val = 1'b1;
        bus.mul_resp_msg = 32'h55;
        bus.out_rdy      = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("rst_out_val", 64'(bus.out_val), 64'd0);
        check("rst_out_msg", 64'(bus.out_msg), 64'd0);
        check("rst_out_count", 64'(bus.out_count), 64'd0);
        check("rst_mul_resp_rdy", 64'(bus.mul_resp_rdy), 64'd0);
        check("rst_in_req_rdy", 64'(bus.in_req_rdy), 64'd1);
        check("rst_mul_req_val", 64'(bus.mul_req_val), 64'd1);
        bus.mul_req_rdy = 1'b0;
        bus.in_req_val  = 1'b0;
        #1;
        check("rst_in_req_rdy_low", 64'(bus.in_req_rdy), 64'd0);
        check("rst_mul_req_val_low", 64'(bus.mul_req_val), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 drive();

        // Single pair: result must be visible the cycle after the product is consumed.
        load_vec(vecs[0], 1'b1);
        drive();
        last_pf = 1'b0;
        n = 0;
        while (!last_pf && n < 20) begin
            tick();
            n++;
        end
        #1;
        check("lat_out_val", 64'(bus.out_val), 64'd1);
        check("lat_out_msg", 64'(bus.out_msg), 64'd15);
        check("lat_out_count", 64'(bus.out_count), 64'd1);
        wait_idle("single", 50);

        // Three-pair group produces exactly one result pulse.
        f0 = out_fires;
        load_vec(vecs[1], 1'b1);
        drive();
        wait_idle("group3", 50);
        check("group3_pulses", 64'(out_fires - f0), 64'd1);

        // Backpressure: the flag queue fills, a pop frees a slot only on the next cycle.
        resp_en = 1'b0;
        v = '{n: 3'd3, a: {32'd1, 32'd3, 32'd5, 32'd0}, b: {32'd2, 32'd4, 32'd6, 32'd0},
              exp: '{sum: 32'd44, cnt: 8'd3}};
        load_vec(v, 1'b1);
        drive();
        tick();
        tick();
        #1;
        check("bp_in_req_rdy_full", 64'(bus.in_req_rdy), 64'd0);
        check("bp_mul_req_val_full", 64'(bus.mul_req_val), 64'd0);
        tick();
        tick();
        #1;
        check("bp_in_req_rdy_hold", 64'(bus.in_req_rdy), 64'd0);
        resp_en = 1'b1;
        drive();
        #1;
        check("bp_mul_resp_rdy", 64'(bus.mul_resp_rdy), 64'd1);
        check("bp_no_same_cycle", 64'(bus.in_req_rdy), 64'd0);
        tick();
        #1;
        check("bp_accept_next", 64'(bus.in_req_rdy), 64'd1);
        wait_idle("backpressure", 50);

        // DONE stall: the next group's products wait while the result is held.
        out_rdy_en = 1'b0;
        v = '{n: 3'd1, a: {32'd1, 32'd0, 32'd0, 32'd0}, b: {32'd1, 32'd0, 32'd0, 32'd0},
              exp: '{sum: 32'd1, cnt: 8'd1}};
        load_vec(v, 1'b1);
        v = '{n: 3'd2, a: {32'd2, 32'd3, 32'd0, 32'd0}, b: {32'd2, 32'd3, 32'd0, 32'd0},
              exp: '{sum: 32'd13, cnt: 8'd2}};
        load_vec(v, 1'b1);
        drive();
        n = 0;
        while (bus.out_val !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("stall_out_val", 64'(bus.out_val), 64'd1);
            check("stall_mul_resp_rdy", 64'(bus.mul_resp_rdy), 64'd0);
            check("stall_out_msg", 64'(bus.out_msg), 64'(exp_q[0].sum));
            tick();
            #1;
        end
        out_rdy_en = 1'b1;
        drive();
        wait_idle("stall", 50);

        // Table of groups, queued back to back, then again with random handshake gaps.
        for (int pass = 0; pass < 2; pass++) begin
            jitter = (pass == 1);
            for (int i = 0; i < 6; i++) load_vec(vecs[i], 1'b1);
            drive();
            wait_idle(pass == 0 ? "table" : "table_jitter", 400);
        end
        jitter = 1'b0;
        drive();

        // Count saturation with 300 unit products.
        for (int i = 0; i < 300; i++)
            src.push_back('{last: (i == 299), a: 32'd1, b: 32'd1});
        exp_q.push_back('{sum: 32'd300, cnt: 8'd255});
        drive();
        wait_idle("saturate", 1000);

        // Reset mid-group discards the partial sum and any stale product.
        v = '{n: 3'd1, a: {32'd5, 32'd0, 32'd0, 32'd0}, b: {32'd5, 32'd0, 32'd0, 32'd0},
              exp: '{sum: 32'd0, cnt: 8'd0}};
        src.push_back('{last: 1'b0, a: 32'd5, b: 32'd5});
        drive();
        last_pf = 1'b0;
        n = 0;
        while (!last_pf && n < 20) begin
            tick();
            n++;
        end
        #1 reset = 1'b0;
        #1;
        check("midrst_mul_resp_rdy", 64'(bus.mul_resp_rdy), 64'd0);
        src.delete();
        mq.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        mq.push_back(32'hDEAD);
        drive();
        #1;
        check("stale_mul_resp_rdy", 64'(bus.mul_resp_rdy), 64'd0);
        tick();
        #1;
        check("stale_mul_resp_rdy_2", 64'(bus.mul_resp_rdy), 64'd0);
        mq.delete();
        drive();
        src.push_back('{last: 1'b1, a: 32'd1, b: 32'd9});
        exp_q.push_back('{sum: 32'd9, cnt: 8'd1});
        drive();
        wait_idle("after_reset", 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
